// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM-to-WB handoff bundle.
// MEM drives the master side and WB (wb_stage) consumes it through the slave side.
interface wb_stage_if;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_rf_wdata;
  logic [31:0] ms_vaddr;
  logic        ms_csr_re;
  logic [85:0] ms_ex_zip;
  logic        ws_allowin;

  modport master (
    output ms_to_ws_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
           ms_vaddr, ms_csr_re, ms_ex_zip,
    input  ws_allowin
  );

  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
           ms_vaddr, ms_csr_re, ms_ex_zip,
    output ws_allowin
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: last pipeline stage; commits GPR/CSR writes and raises exception/ertn flushes.
// Define WB_DEBUG_TRACE_EN to drive the difftest trace ports; otherwise they are tied to 0.
module wb_stage (
  input  logic        clk,
  input  logic        resetn,
  wb_stage_if.slave   ms,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        csr_re,
  output logic [13:0] csr_num,
  input  logic [31:0] csr_rvalue,
  output logic        csr_we,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        wb_ex,
  output logic        wb_ertn,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_badv,
  output logic        wb_badv_we,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  logic        ws_valid_q,    ws_valid_d;
  logic [31:0] ws_pc_q,       ws_pc_d;
  logic        ws_rf_we_q,    ws_rf_we_d;
  logic [4:0]  ws_rf_waddr_q, ws_rf_waddr_d;
  logic [31:0] ws_rf_wdata_q, ws_rf_wdata_d;
  logic [31:0] ws_vaddr_q,    ws_vaddr_d;
  logic        ws_csr_re_q,   ws_csr_re_d;
  logic [85:0] ws_ex_zip_q,   ws_ex_zip_d;

  logic ws_ready_go;
  logic ws_allowin;
  logic ws_exc;

  assign ws_ready_go   = 1'b1;
  assign ws_allowin    = !ws_valid_q || ws_ready_go;
  assign ms.ws_allowin = ws_allowin;

  // A committing exception/ertn kills whatever MEM hands over in the same cycle.
  always_comb begin
    ws_valid_d    = ws_valid_q;
    ws_pc_d       = ws_pc_q;
    ws_rf_we_d    = ws_rf_we_q;
    ws_rf_waddr_d = ws_rf_waddr_q;
    ws_rf_wdata_d = ws_rf_wdata_q;
    ws_vaddr_d    = ws_vaddr_q;
    ws_csr_re_d   = ws_csr_re_q;
    ws_ex_zip_d   = ws_ex_zip_q;
    if (ms.ms_to_ws_valid && ws_allowin) begin
      ws_pc_d       = ms.ms_pc;
      ws_rf_we_d    = ms.ms_rf_we;
      ws_rf_waddr_d = ms.ms_rf_waddr;
      ws_rf_wdata_d = ms.ms_rf_wdata;
      ws_vaddr_d    = ms.ms_vaddr;
      ws_csr_re_d   = ms.ms_csr_re;
      ws_ex_zip_d   = ms.ms_ex_zip;
    end
    if (wb_ex || wb_ertn) begin
      ws_valid_d = 1'b0;
    end else if (ws_allowin) begin
      ws_valid_d = ms.ms_to_ws_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ws_valid_q    <= 1'b0;
      ws_pc_q       <= '0;
      ws_rf_we_q    <= 1'b0;
      ws_rf_waddr_q <= '0;
      ws_rf_wdata_q <= '0;
      ws_vaddr_q    <= '0;
      ws_csr_re_q   <= 1'b0;
      ws_ex_zip_q   <= '0;
    end else begin
      ws_valid_q    <= ws_valid_d;
      ws_pc_q       <= ws_pc_d;
      ws_rf_we_q    <= ws_rf_we_d;
      ws_rf_waddr_q <= ws_rf_waddr_d;
      ws_rf_wdata_q <= ws_rf_wdata_d;
      ws_vaddr_q    <= ws_vaddr_d;
      ws_csr_re_q   <= ws_csr_re_d;
      ws_ex_zip_q   <= ws_ex_zip_d;
    end
  end

  assign ws_exc  = ws_valid_q && (|ws_ex_zip_q[5:0]);
  assign wb_ex   = ws_exc;
  assign wb_ertn = ws_valid_q && ws_ex_zip_q[6] && !ws_exc;
  assign wb_pc   = ws_pc_q;

  // Cause priority: interrupt, adef, syscall, break, ine, ale.
  always_comb begin
    wb_ecode = 6'h00;
    if (ws_exc) begin
      if      (ws_ex_zip_q[5]) wb_ecode = 6'h00;
      else if (ws_ex_zip_q[4]) wb_ecode = 6'h08;
      else if (ws_ex_zip_q[3]) wb_ecode = 6'h0B;
      else if (ws_ex_zip_q[2]) wb_ecode = 6'h0C;
      else if (ws_ex_zip_q[1]) wb_ecode = 6'h0D;
      else if (ws_ex_zip_q[0]) wb_ecode = 6'h09;
    end
  end

  assign wb_esubcode = 9'h000;

  always_comb begin
    wb_badv = 32'h0;
    if (ws_exc) begin
      if      (ws_ex_zip_q[4]) wb_badv = ws_pc_q;
      else if (ws_ex_zip_q[0]) wb_badv = ws_vaddr_q;
    end
  end

  // An interrupt outranks adef/ale, so BADV must not be touched when one is pending.
  assign wb_badv_we = ws_exc && !ws_ex_zip_q[5] && (ws_ex_zip_q[4] || ws_ex_zip_q[0]);

  assign csr_num    = ws_ex_zip_q[20:7];
  assign csr_re     = ws_valid_q && ws_csr_re_q;
  assign csr_we     = ws_valid_q && ws_ex_zip_q[85] && !ws_exc;
  assign csr_wmask  = ws_ex_zip_q[84:53];
  assign csr_wvalue = ws_ex_zip_q[52:21];

  assign rf_we    = ws_valid_q && ws_rf_we_q && !ws_exc;
  assign rf_waddr = ws_rf_waddr_q;
  assign rf_wdata = ws_csr_re_q ? csr_rvalue : ws_rf_wdata_q;

`ifdef WB_DEBUG_TRACE_EN
  assign debug_wb_pc       = ws_pc_q;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`else
  assign debug_wb_pc       = 32'h0;
  assign debug_wb_rf_we    = 4'h0;
  assign debug_wb_rf_wnum  = 5'h0;
  assign debug_wb_rf_wdata = 32'h0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed vector table, hand-written flush/reset sequences,
// and randomized traffic checked against a commit-rule reference model.
module tb_wb_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] vaddr;
    logic        csr_re;
    logic [85:0] zip;
    logic [31:0] rvalue;
  } in_t;

  typedef struct packed {
    logic        allowin;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        csr_re;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ex;
    logic        ertn;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] pc;
    logic [31:0] badv;
    logic        badv_we;
    logic [31:0] dbg_pc;
    logic [3:0]  dbg_we;
    logic [4:0]  dbg_wnum;
    logic [31:0] dbg_wdata;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  wb_stage_if ms_if ();

  logic [31:0] csr_rvalue;
  logic        rf_we, csr_re, csr_we, wb_ex, wb_ertn, wb_badv_we;
  logic [4:0]  rf_waddr, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, csr_wmask, csr_wvalue, wb_pc, wb_badv;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [13:0] csr_num;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [3:0]  debug_wb_rf_we;

  int n_vec = 0;
  int n_bad = 0;

  wb_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ms                (ms_if.slave),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .csr_re            (csr_re),
    .csr_num           (csr_num),
    .csr_rvalue        (csr_rvalue),
    .csr_we            (csr_we),
    .csr_wmask         (csr_wmask),
    .csr_wvalue        (csr_wvalue),
    .wb_ex             (wb_ex),
    .wb_ertn           (wb_ertn),
    .wb_ecode          (wb_ecode),
    .wb_esubcode       (wb_esubcode),
    .wb_pc             (wb_pc),
    .wb_badv           (wb_badv),
    .wb_badv_we        (wb_badv_we),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  function automatic logic [85:0] mk_zip(input logic cwe, input logic [31:0] mask,
                                         input logic [31:0] value, input logic [13:0] num,
                                         input logic [6:0] flags);
    return {cwe, mask, value, num, flags};
  endfunction

  function automatic in_t mk_in(input logic [31:0] pc, input logic rwe, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [31:0] va, input logic cre,
                                input logic [85:0] zip, input logic [31:0] rv);
    in_t r;
    r.pc = pc; r.rf_we = rwe; r.waddr = wa; r.wdata = wd;
    r.vaddr = va; r.csr_re = cre; r.zip = zip; r.rvalue = rv;
    return r;
  endfunction

  function automatic out_t zero_out();
    out_t o = '0;
    o.allowin = 1'b1;
    return o;
  endfunction

  function automatic out_t with_dbg(input out_t o);
    out_t r = o;
`ifdef WB_DEBUG_TRACE_EN
    r.dbg_pc    = o.pc;
    r.dbg_we    = {4{o.rf_we}};
    r.dbg_wnum  = o.rf_waddr;
    r.dbg_wdata = o.rf_wdata;
`else
    r.dbg_pc    = '0;
    r.dbg_we    = '0;
    r.dbg_wnum  = '0;
    r.dbg_wdata = '0;
`endif
    return r;
  endfunction

  // Commit rules for whatever instruction currently sits in WB.
  function automatic out_t model(input logic valid, input in_t i, input logic [31:0] rv);
    out_t o = zero_out();
    logic [5:0] causes = i.zip[5:0];
    logic exc = valid && (causes != 6'h0);
    int win = -1;
    for (int k = 5; k >= 0; k--)
      if (win < 0 && causes[k]) win = k;
    if (exc) begin
      case (win)
        5: o.ecode = 6'h00;
        4: o.ecode = 6'h08;
        3: o.ecode = 6'h0B;
        2: o.ecode = 6'h0C;
        1: o.ecode = 6'h0D;
        default: o.ecode = 6'h09;
      endcase
      o.badv    = causes[4] ? i.pc : (causes[0] ? i.vaddr : 32'h0);
      o.badv_we = !causes[5] && (causes[4] || causes[0]);
    end
    o.ex         = exc;
    o.ertn       = valid && i.zip[6] && !exc;
    o.csr_re     = valid && i.csr_re;
    o.csr_we     = valid && i.zip[85] && !exc;
    o.csr_num    = i.zip[20:7];
    o.csr_wmask  = i.zip[84:53];
    o.csr_wvalue = i.zip[52:21];
    o.rf_we      = valid && i.rf_we && !exc;
    o.rf_waddr   = i.waddr;
    o.rf_wdata   = i.csr_re ? rv : i.wdata;
    o.pc         = i.pc;
    return with_dbg(o);
  endfunction

  task automatic applyStimulus(input logic valid, input in_t i);
    ms_if.ms_to_ws_valid = valid;
    ms_if.ms_pc          = i.pc;
    ms_if.ms_rf_we       = i.rf_we;
    ms_if.ms_rf_waddr    = i.waddr;
    ms_if.ms_rf_wdata    = i.wdata;
    ms_if.ms_vaddr       = i.vaddr;
    ms_if.ms_csr_re      = i.csr_re;
    ms_if.ms_ex_zip      = i.zip;
    csr_rvalue           = i.rvalue;
  endtask

  task automatic cmp(input string tag, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s.%s: got %h, want %h", tag, name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input out_t e);
    n_vec++;
    cmp(tag, "ws_allowin", 32'(ms_if.ws_allowin), 32'(e.allowin));
    cmp(tag, "rf_we",      32'(rf_we),            32'(e.rf_we));
    cmp(tag, "rf_waddr",   32'(rf_waddr),         32'(e.rf_waddr));
    cmp(tag, "rf_wdata",   rf_wdata,              e.rf_wdata);
    cmp(tag, "csr_re",     32'(csr_re),           32'(e.csr_re));
    cmp(tag, "csr_num",    32'(csr_num),          32'(e.csr_num));
    cmp(tag, "csr_we",     32'(csr_we),           32'(e.csr_we));
    cmp(tag, "csr_wmask",  csr_wmask,             e.csr_wmask);
    cmp(tag, "csr_wvalue", csr_wvalue,            e.csr_wvalue);
    cmp(tag, "wb_ex",      32'(wb_ex),            32'(e.ex));
    cmp(tag, "wb_ertn",    32'(wb_ertn),          32'(e.ertn));
    cmp(tag, "wb_ecode",   32'(wb_ecode),         32'(e.ecode));
    cmp(tag, "wb_esubcode",32'(wb_esubcode),      32'(e.esubcode));
    cmp(tag, "wb_pc",      wb_pc,                 e.pc);
    cmp(tag, "wb_badv",    wb_badv,               e.badv);
    cmp(tag, "wb_badv_we", 32'(wb_badv_we),       32'(e.badv_we));
    cmp(tag, "dbg_pc",     debug_wb_pc,           e.dbg_pc);
    cmp(tag, "dbg_we",     32'(debug_wb_rf_we),   32'(e.dbg_we));
    cmp(tag, "dbg_wnum",   32'(debug_wb_rf_wnum), 32'(e.dbg_wnum));
    cmp(tag, "dbg_wdata",  debug_wb_rf_wdata,     e.dbg_wdata);
  endtask

  function automatic in_t add_in(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd);
    return mk_in(pc, 1'b1, wa, wd, 32'h0, 1'b0, 86'h0, 32'h0);
  endfunction

  function automatic out_t add_exp(input logic [31:0] pc, input logic [4:0] wa,
                                   input logic [31:0] wd, input logic we);
    out_t o = zero_out();
    o.rf_we = we; o.rf_waddr = wa; o.rf_wdata = wd; o.pc = pc;
    return with_dbg(o);
  endfunction

  function automatic in_t rand_in();
    logic [6:0] flags;
    for (int b = 0; b < 7; b++) flags[b] = ($urandom_range(0, 7) == 0);
    return mk_in($urandom, 1'($urandom), 5'($urandom), $urandom, $urandom, 1'($urandom),
                 mk_zip(1'($urandom), $urandom, $urandom, 14'($urandom), flags), $urandom);
  endfunction

  vec_t vt [9];
  in_t  idle_in;
  in_t  cur;
  in_t  mdl_instr;
  logic mdl_valid;
  logic cur_valid;
  logic mdl_flush;
  out_t e;

  initial begin
    idle_in = mk_in(32'h0, 1'b0, 5'h0, 32'h0, 32'h0, 1'b0, 86'h0, 32'h0);

    // Directed table: one accepted instruction followed by a bubble.
    vt[0].in = add_in(32'h1c000010, 5'd5, 32'h12345678);
    vt[0].exp = add_exp(32'h1c000010, 5'd5, 32'h12345678, 1'b1);

    vt[1].in = mk_in(32'h1c000014, 1'b1, 5'd7, 32'h0000dead, 32'h0, 1'b1,
                     mk_zip(1'b0, 32'h0, 32'h0, 14'h006, 7'h00), 32'h0000abcd);
    vt[1].exp = zero_out();
    vt[1].exp.csr_re = 1'b1; vt[1].exp.csr_num = 14'h006; vt[1].exp.rf_we = 1'b1;
    vt[1].exp.rf_waddr = 5'd7; vt[1].exp.rf_wdata = 32'h0000abcd; vt[1].exp.pc = 32'h1c000014;
    vt[1].exp = with_dbg(vt[1].exp);

    vt[2].in = mk_in(32'h1c000018, 1'b1, 5'd3, 32'h00000011, 32'h0, 1'b0,
                     mk_zip(1'b1, 32'hffffffff, 32'h00000055, 14'h006, 7'h08), 32'h0);
    vt[2].exp = zero_out();
    vt[2].exp.ex = 1'b1; vt[2].exp.ecode = 6'h0B; vt[2].exp.csr_num = 14'h006;
    vt[2].exp.csr_wmask = 32'hffffffff; vt[2].exp.csr_wvalue = 32'h00000055;
    vt[2].exp.rf_waddr = 5'd3; vt[2].exp.rf_wdata = 32'h00000011; vt[2].exp.pc = 32'h1c000018;
    vt[2].exp = with_dbg(vt[2].exp);

    vt[3].in = mk_in(32'h1c00001c, 1'b1, 5'd4, 32'h0, 32'h1c000103, 1'b0,
                     mk_zip(1'b0, 32'h0, 32'h0, 14'h0, 7'h21), 32'h0);
    vt[3].exp = zero_out();
    vt[3].exp.ex = 1'b1; vt[3].exp.ecode = 6'h00; vt[3].exp.badv = 32'h1c000103;
    vt[3].exp.rf_waddr = 5'd4; vt[3].exp.pc = 32'h1c00001c;
    vt[3].exp = with_dbg(vt[3].exp);

    vt[4].in = mk_in(32'h1c00001c, 1'b1, 5'd4, 32'h0, 32'h1c000103, 1'b0,
                     mk_zip(1'b0, 32'h0, 32'h0, 14'h0, 7'h01), 32'h0);
    vt[4].exp = zero_out();
    vt[4].exp.ex = 1'b1; vt[4].exp.ecode = 6'h09; vt[4].exp.badv = 32'h1c000103;
    vt[4].exp.badv_we = 1'b1; vt[4].exp.rf_waddr = 5'd4; vt[4].exp.pc = 32'h1c00001c;
    vt[4].exp = with_dbg(vt[4].exp);

    vt[5].in = mk_in(32'h1c000020, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0,
                     mk_zip(1'b0, 32'h0, 32'h0, 14'h0, 7'h40), 32'h0);
    vt[5].exp = zero_out();
    vt[5].exp.ertn = 1'b1; vt[5].exp.pc = 32'h1c000020;
    vt[5].exp = with_dbg(vt[5].exp);

    vt[6].in = mk_in(32'h1c000024, 1'b1, 5'd9, 32'h0, 32'h0, 1'b1,
                     mk_zip(1'b1, 32'h0000000f, 32'h00000003, 14'h004, 7'h00), 32'h00000077);
    vt[6].exp = zero_out();
    vt[6].exp.csr_re = 1'b1; vt[6].exp.csr_we = 1'b1; vt[6].exp.csr_num = 14'h004;
    vt[6].exp.csr_wmask = 32'h0000000f; vt[6].exp.csr_wvalue = 32'h00000003;
    vt[6].exp.rf_we = 1'b1; vt[6].exp.rf_waddr = 5'd9; vt[6].exp.rf_wdata = 32'h00000077;
    vt[6].exp.pc = 32'h1c000024;
    vt[6].exp = with_dbg(vt[6].exp);

    vt[7].in = mk_in(32'h1c000021, 1'b1, 5'd2, 32'h0, 32'h00000999, 1'b0,
                     mk_zip(1'b0, 32'h0, 32'h0, 14'h0, 7'h10), 32'h0);
    vt[7].exp = zero_out();
    vt[7].exp.ex = 1'b1; vt[7].exp.ecode = 6'h08; vt[7].exp.badv = 32'h1c000021;
    vt[7].exp.badv_we = 1'b1; vt[7].exp.rf_waddr = 5'd2; vt[7].exp.pc = 32'h1c000021;
    vt[7].exp = with_dbg(vt[7].exp);

    vt[8].in = mk_in(32'h1c000028, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0,
                     mk_zip(1'b0, 32'h0, 32'h0, 14'h0, 7'h06), 32'h0);
    vt[8].exp = zero_out();
    vt[8].exp.ex = 1'b1; vt[8].exp.ecode = 6'h0C; vt[8].exp.pc = 32'h1c000028;
    vt[8].exp = with_dbg(vt[8].exp);

    // Reset state.
    resetn = 1'b0;
    applyStimulus(1'b0, idle_in);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", with_dbg(zero_out()));
    resetn = 1'b1;

    foreach (vt[k]) begin
      applyStimulus(1'b1, vt[k].in);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d", k), vt[k].exp);
      applyStimulus(1'b0, vt[k].in);
      @(posedge clk); #1;
      e = vt[k].exp;
      e.rf_we = 1'b0; e.csr_we = 1'b0; e.csr_re = 1'b0; e.ex = 1'b0; e.ertn = 1'b0;
      e.badv_we = 1'b0; e.ecode = 6'h0; e.badv = 32'h0;
      checkOutput($sformatf("vec%0d_bubble", k), with_dbg(e));
    end

    // Back-to-back commits, one per cycle.
    applyStimulus(1'b1, add_in(32'h1c000100, 5'd1, 32'h00000001));
    @(posedge clk); #1;
    checkOutput("b2b_0", add_exp(32'h1c000100, 5'd1, 32'h00000001, 1'b1));
    applyStimulus(1'b1, add_in(32'h1c000104, 5'd2, 32'h00000002));
    @(posedge clk); #1;
    checkOutput("b2b_1", add_exp(32'h1c000104, 5'd2, 32'h00000002, 1'b1));
    applyStimulus(1'b1, add_in(32'h1c000108, 5'd3, 32'h00000003));
    @(posedge clk); #1;
    checkOutput("b2b_2", add_exp(32'h1c000108, 5'd3, 32'h00000003, 1'b1));

    // Syscall flushes the instruction MEM presents during its commit cycle.
    applyStimulus(1'b1, vt[2].in);
    @(posedge clk); #1;
    checkOutput("sys_pulse", vt[2].exp);
    applyStimulus(1'b1, add_in(32'h1c00001c, 5'd10, 32'h0000aaaa));
    @(posedge clk); #1;
    checkOutput("sys_flushed", add_exp(32'h1c00001c, 5'd10, 32'h0000aaaa, 1'b0));
    applyStimulus(1'b1, add_in(32'h1c000200, 5'd11, 32'h0000bbbb));
    @(posedge clk); #1;
    checkOutput("sys_resume", add_exp(32'h1c000200, 5'd11, 32'h0000bbbb, 1'b1));

    // Ertn flushes likewise.
    applyStimulus(1'b1, vt[5].in);
    @(posedge clk); #1;
    checkOutput("ertn_pulse", vt[5].exp);
    applyStimulus(1'b1, add_in(32'h1c000024, 5'd12, 32'h0000cccc));
    @(posedge clk); #1;
    checkOutput("ertn_flushed", add_exp(32'h1c000024, 5'd12, 32'h0000cccc, 1'b0));

    // Reset during a pending exception wins.
    applyStimulus(1'b1, vt[2].in);
    @(posedge clk); #1;
    checkOutput("rst_pre", vt[2].exp);
    resetn = 1'b0;
    applyStimulus(1'b1, add_in(32'h1c000300, 5'd13, 32'h0000dddd));
    @(posedge clk); #1;
    checkOutput("rst_during", with_dbg(zero_out()));
    resetn = 1'b1;

    // Randomized traffic against the reference model.
    mdl_valid = 1'b0;
    mdl_instr = '0;
    for (int n = 0; n < 400; n++) begin
      cur       = rand_in();
      cur_valid = ($urandom_range(0, 3) != 0);
      resetn    = ($urandom_range(0, 24) != 0);
      applyStimulus(cur_valid, cur);
      @(posedge clk); #1;
      if (!resetn) begin
        mdl_valid = 1'b0;
        mdl_instr = '0;
      end else begin
        e = model(mdl_valid, mdl_instr, 32'h0);
        mdl_flush = e.ex || e.ertn;
        if (cur_valid) mdl_instr = cur;
        mdl_valid = mdl_flush ? 1'b0 : cur_valid;
      end
      checkOutput($sformatf("rand%0d", n), model(mdl_valid, mdl_instr, csr_rvalue));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
